// File: rtl/puf_resp_ctrl.sv
// RO-PUF challenge/response controller: settles each RO pair, counts edges over a window, packs compare bits.
// Optional build macro PUF_TIE_FLAG_EN adds the tie_mask output flagging unreliable (tied/saturated) bits.
module puf_resp_ctrl #(
    parameter int CNT_W     = 8,
    parameter int WINDOW    = 256,
    parameter int SETTLE    = 16,
    parameter int RESP_BITS = 8,
    parameter int SEL_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,      // synchronous, active-high despite the legacy name
    input  logic                 start,
    input  logic [SEL_W-1:0]     challenge,
    input  logic                 ro_a,
    input  logic                 ro_b,
    output logic                 ro_ena,
    output logic [SEL_W-1:0]     sel,
    output logic                 busy,
    output logic [RESP_BITS-1:0] resp,
    output logic                 resp_valid,
    input  logic                 resp_ready
`ifdef PUF_TIE_FLAG_EN
    ,
    output logic [RESP_BITS-1:0] tie_mask
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_MEASURE = 3'd2;
    localparam logic [2:0] S_COMPARE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam int TMR_W = $clog2((WINDOW > SETTLE) ? WINDOW : SETTLE);
    localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(RESP_BITS - 1);

    logic [2:0]       state;
    logic [TMR_W-1:0] tmr;
    logic [IDX_W-1:0] idx;
    logic [2:0]       sync_a;
    logic [2:0]       sync_b;
    logic             edge_a;
    logic             edge_b;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    // [0],[1] form the synchronizer; [2] is history, so an edge is seen for exactly one clk.
    assign edge_a = sync_a[1] & ~sync_a[2];
    assign edge_b = sync_b[1] & ~sync_b[2];
    assign busy   = (state != S_IDLE);

    // NOTE: every flop here uses non-blocking assignment so all registers update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[1:0], ro_a};
            sync_b <= {sync_b[1:0], ro_b};
        end
    end

    // Counters only run in MEASURE, so they are zero throughout SETTLE and re-armed for every bit.
    always_ff @(posedge clk) begin
        if (rst_n || state != S_MEASURE) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (edge_a && cnt_a != CNT_MAX) cnt_a <= cnt_a + CNT_W'(1);
            if (edge_b && cnt_b != CNT_MAX) cnt_b <= cnt_b + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= S_IDLE;
            tmr        <= '0;
            idx        <= '0;
            sel        <= '0;
            ro_ena     <= 1'b0;
            resp       <= '0;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sel    <= challenge;
                        resp   <= '0;
                        idx    <= '0;
                        tmr    <= '0;
                        ro_ena <= 1'b1;
                        state  <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (tmr == SETTLE_LAST) begin
                        tmr   <= '0;
                        state <= S_MEASURE;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                S_MEASURE: begin
                    if (tmr == WINDOW_LAST) begin
                        tmr   <= '0;
                        state <= S_COMPARE;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                S_COMPARE: begin
                    resp[idx] <= (cnt_a > cnt_b);
                    if (idx == IDX_LAST) begin
                        ro_ena <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        sel   <= sel + SEL_W'(1);
                        state <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    // valid rises one cycle after entry; the transfer happens on the valid&ready edge
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PUF_TIE_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst_n) begin
            tie_mask <= '0;
        end else if (state == S_IDLE && start) begin
            tie_mask <= '0;
        end else if (state == S_COMPARE) begin
            tie_mask[idx] <= (cnt_a == cnt_b) | (cnt_a == CNT_MAX) | (cnt_b == CNT_MAX);
        end
    end
`endif

endmodule

// File: tb/tb_puf_resp_ctrl.sv
// Directed bench for puf_resp_ctrl (WINDOW=16, SETTLE=4, RESP_BITS=4); a second instance uses CNT_W=3.
// Define PUF_TIE_FLAG_EN for both bench and RTL to also check tie_mask.
module tb_puf_resp_ctrl;

    localparam int WINDOW    = 16;
    localparam int SETTLE    = 4;
    localparam int RESP_BITS = 4;
    localparam int SEL_W     = 5;
    localparam int BIT_CYC   = SETTLE + WINDOW + 1;
    localparam int LATENCY   = RESP_BITS * BIT_CYC + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [4:0] challenge = '0;
    logic       ro_a = 1'b0;
    logic       ro_b = 1'b0;
    logic       resp_ready = 1'b0;

    logic       ro_ena, busy, resp_valid;
    logic [4:0] sel;
    logic [3:0] resp;
    logic       ro_ena3, busy3, resp_valid3;
    logic [4:0] sel3;
    logic [3:0] resp3;
`ifdef PUF_TIE_FLAG_EN
    logic [3:0] tie_mask, tie_mask3;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int period_a = 0;
    int period_b = 0;
    int gcyc = 0;

    puf_resp_ctrl #(.CNT_W(8), .WINDOW(WINDOW), .SETTLE(SETTLE), .RESP_BITS(RESP_BITS), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
        .ro_a(ro_a), .ro_b(ro_b), .ro_ena(ro_ena), .sel(sel), .busy(busy),
        .resp(resp), .resp_valid(resp_valid), .resp_ready(resp_ready)
`ifdef PUF_TIE_FLAG_EN
        , .tie_mask(tie_mask)
`endif
    );

    puf_resp_ctrl #(.CNT_W(3), .WINDOW(WINDOW), .SETTLE(SETTLE), .RESP_BITS(RESP_BITS), .SEL_W(SEL_W)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
        .ro_a(ro_a), .ro_b(ro_b), .ro_ena(ro_ena3), .sel(sel3), .busy(busy3),
        .resp(resp3), .resp_valid(resp_valid3), .resp_ready(resp_ready)
`ifdef PUF_TIE_FLAG_EN
        , .tie_mask(tie_mask3)
`endif
    );

    always #5 clk = ~clk;

    // RO stand-ins: square waves with periods in clk cycles, changing on the falling edge.
    always @(negedge clk) begin
        gcyc = gcyc + 1;
        ro_a = (period_a != 0) && ((gcyc % period_a) < (period_a / 2));
        ro_b = (period_b != 0) && ((gcyc % period_b) < (period_b / 2));
    end

    task automatic run_resp(input logic [4:0] ch, output logic [19:0] sels, output int lat,
                            output logic [3:0] r, output logic [3:0] r3,
                            output logic [3:0] tm, output logic [3:0] tm3);
        sels = '0;
        lat  = -1;
        @(negedge clk);
        challenge = ch;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if ((c % BIT_CYC) == 10 && (c / BIT_CYC) < RESP_BITS)
                sels[(c / BIT_CYC) * SEL_W +: SEL_W] = sel;
            if (resp_valid) begin
                lat = c;
                break;
            end
        end
        r  = resp;
        r3 = resp3;
`ifdef PUF_TIE_FLAG_EN
        tm  = tie_mask;
        tm3 = tie_mask3;
`else
        tm  = '0;
        tm3 = '0;
`endif
    endtask

    task automatic accept(output logic v, output logic b);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        v = resp_valid;
        b = busy;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({ro_ena, busy, resp_valid} !== 3'b000)
            $display("FAIL reset_ctrl: ro_ena/busy/valid=%b want 000", {ro_ena, busy, resp_valid});
        else n_pass++;
        n_total++;
        if (sel !== 5'd0) $display("FAIL reset_sel: got %0d want 0", sel); else n_pass++;
        n_total++;
        if (resp !== 4'b0000) $display("FAIL reset_resp: got %b want 0000", resp); else n_pass++;
`ifdef PUF_TIE_FLAG_EN
        n_total++;
        if (tie_mask !== 4'b0000) $display("FAIL reset_tie: got %b want 0000", tie_mask); else n_pass++;
`endif
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic test_basic();
        logic [19:0] sels;
        int lat;
        logic [3:0] r, r3, tm, tm3;
        logic v, b;
        period_a = 4;
        period_b = 8;
        run_resp(5'd3, sels, lat, r, r3, tm, tm3);
        n_total++;
        if (lat !== LATENCY) $display("FAIL t1_latency: got %0d want %0d", lat, LATENCY); else n_pass++;
        n_total++;
        if (sels !== {5'd6, 5'd5, 5'd4, 5'd3}) $display("FAIL t1_sel_seq: got %h want %h", sels, {5'd6, 5'd5, 5'd4, 5'd3});
        else n_pass++;
        n_total++;
        if (r !== 4'b1111) $display("FAIL t1_resp: got %b want 1111", r); else n_pass++;
        n_total++;
        if ({ro_ena, busy} !== 2'b01) $display("FAIL t1_done_ena_busy: got %b want 01", {ro_ena, busy}); else n_pass++;
`ifdef PUF_TIE_FLAG_EN
        n_total++;
        if (tm !== 4'b0000) $display("FAIL t1_tie: got %b want 0000", tm); else n_pass++;
`endif
        accept(v, b);
        n_total++;
        if ({v, b} !== 2'b00) $display("FAIL t1_accept: valid/busy=%b want 00", {v, b}); else n_pass++;
    endtask

    task automatic test_swap();
        logic [19:0] sels;
        int lat;
        logic [3:0] r, r3, tm, tm3;
        logic v, b;
        period_a = 8;
        period_b = 4;
        run_resp(5'd9, sels, lat, r, r3, tm, tm3);
        n_total++;
        if (r !== 4'b0000) $display("FAIL t2_resp: got %b want 0000", r); else n_pass++;
        n_total++;
        if (sels !== {5'd12, 5'd11, 5'd10, 5'd9}) $display("FAIL t2_sel_seq: got %h", sels); else n_pass++;
        accept(v, b);
    endtask

    task automatic test_tie();
        logic [19:0] sels;
        int lat;
        logic [3:0] r, r3, tm, tm3;
        logic v, b;
        period_a = 4;
        period_b = 4;
        run_resp(5'd0, sels, lat, r, r3, tm, tm3);
        n_total++;
        if (r !== 4'b0000) $display("FAIL t3_resp_tie: got %b want 0000", r); else n_pass++;
`ifdef PUF_TIE_FLAG_EN
        n_total++;
        if (tm !== 4'b1111) $display("FAIL t3_tie_mask: got %b want 1111", tm); else n_pass++;
`endif
        accept(v, b);
    endtask

    task automatic test_saturate();
        logic [19:0] sels;
        int lat;
        logic [3:0] r, r3, tm, tm3;
        logic v, b;
        period_a = 2;
        period_b = 8;
        run_resp(5'd17, sels, lat, r, r3, tm, tm3);
        n_total++;
        if (r3 !== 4'b1111) $display("FAIL t4_resp_cnt3: got %b want 1111", r3); else n_pass++;
        n_total++;
        if (r !== 4'b1111) $display("FAIL t4_resp_cnt8: got %b want 1111", r); else n_pass++;
`ifdef PUF_TIE_FLAG_EN
        n_total++;
        if (tm3 !== 4'b1111) $display("FAIL t4_tie_sat: got %b want 1111", tm3); else n_pass++;
        n_total++;
        if (tm !== 4'b0000) $display("FAIL t4_tie_nosat: got %b want 0000", tm); else n_pass++;
`endif
        accept(v, b);
    endtask

    task automatic test_backpressure();
        logic [19:0] sels;
        int lat;
        logic [3:0] r, r3, tm, tm3;
        logic v, b;
        logic stable;
        period_a = 4;
        period_b = 8;
        run_resp(5'd30, sels, lat, r, r3, tm, tm3);
        n_total++;
        if (sels !== {5'd1, 5'd0, 5'd31, 5'd30}) $display("FAIL t5_sel_wrap: got %h want %h", sels, {5'd1, 5'd0, 5'd31, 5'd30});
        else n_pass++;
        n_total++;
        if (r !== 4'b1111) $display("FAIL t5_resp: got %b want 1111", r); else n_pass++;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start     = (i == 3);
            challenge = 5'd7;
            @(posedge clk);
            #1;
            if (resp !== 4'b1111 || resp_valid !== 1'b1 || busy !== 1'b1 || sel !== 5'd1) stable = 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
        n_total++;
        if (stable !== 1'b1) $display("FAIL t5_hold_stable: got %b want 1", stable); else n_pass++;
        accept(v, b);
        n_total++;
        if ({v, b} !== 2'b00) $display("FAIL t5_accept: valid/busy=%b want 00", {v, b}); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({busy, resp} !== 5'b0_1111) $display("FAIL t5_idle_keep: busy/resp=%b want 01111", {busy, resp}); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [19:0] sels;
        int lat;
        logic [3:0] r, r3, tm, tm3;
        logic v, b;
        logic seen;
        period_a = 4;
        period_b = 8;
        @(negedge clk);
        challenge = 5'd3;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        n_total++;
        if ({ro_ena, busy, resp} !== 6'b11_0011) $display("FAIL t6_mid_state: ena/busy/resp=%b want 110011", {ro_ena, busy, resp});
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        n_total++;
        if ({ro_ena, busy, resp_valid, resp} !== 7'b0) $display("FAIL t6_after_reset: ena/busy/valid/resp=%b want 0000000", {ro_ena, busy, resp_valid, resp});
        else n_pass++;
        n_total++;
        if (sel !== 5'd0) $display("FAIL t6_sel_reset: got %0d want 0", sel); else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid || busy) seen = 1'b1;
        end
        n_total++;
        if (seen !== 1'b0) $display("FAIL t6_no_emit: got %b want 0", seen); else n_pass++;
        run_resp(5'd3, sels, lat, r, r3, tm, tm3);
        n_total++;
        if (lat !== LATENCY) $display("FAIL t6_fresh_latency: got %0d want %0d", lat, LATENCY); else n_pass++;
        n_total++;
        if (r !== 4'b1111) $display("FAIL t6_fresh_resp: got %b want 1111", r); else n_pass++;
        accept(v, b);
        n_total++;
        if (v !== 1'b0) $display("FAIL t6_fresh_accept: got %b want 0", v); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_swap();
        test_tie();
        test_saturate();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
